pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32 pipeline. Each cycle it drives the enable and flush (synchronous clear) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. Its inputs are load-use hazards, taken branches/jumps resolved in EX, instruction-fetch readiness and the data-memory handshake. It also guards data memory with a timeout watchdog and keeps stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 58 +++++
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl_hazard.sv | 24 ++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline stall/flush controller.
// The ctrl_t helpers name the few canonical enable/flush patterns used by the FSM.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    HALT      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c          = '0;
    c.pc_en    = 1'b1;
    c.ifid_en  = 1'b1;
    c.idex_en  = 1'b1;
    c.exmem_en = 1'b1;
    c.memwb_en = 1'b1;
    return c;
  endfunction

  // Everything upstream of WB holds; WB receives a bubble so a retired op is not replayed.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c             = ctrl_run();
    c.pc_en       = 1'b0;
    c.ifid_en     = 1'b0;
    c.idex_en     = 1'b0;
    c.exmem_en    = 1'b0;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c             = '0;
    c.ifid_flush  = 1'b1;
    c.idex_flush  = 1'b1;
    c.exmem_flush = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/handshake inputs and enable/flush/status outputs of the pipeline controller.
// slave is the controller's view; master is the pipeline datapath's view.
interface pipe_ctrl_if #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  imem_ready;
  logic                  dmem_req;
  logic                  dmem_ack;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
    input  ex_branch_taken, imem_ready, dmem_req, dmem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output bus_err, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
    output ex_branch_taken, imem_ready, dmem_req, dmem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  bus_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX
// is about to write. x0 is never a real dependency.
module hazard_unit #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  hazard_o
);

  logic rs1Match;
  logic rs2Match;
  logic rdIsReal;

  assign rdIsReal = (ex_rd_i != '0);
  assign rs1Match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2Match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
  assign hazard_o = ex_mem_read_i && rdIsReal && (rs1Match || rs2Match);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: drives pipeline register enables/flushes, watches the
// data-memory handshake with a timeout, and counts stall cycles and branch redirects.
module pipe_ctrl #(
  parameter int REG_ADDR_W   = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rest,
  pipe_ctrl_if.slave     bus
);

  import pipe_ctrl_pkg::*;

  localparam int                WAIT_W     = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DMEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]  stallCnt_q, flushCnt_q;
  logic              busErr_q, busErr_d;

  logic  hazard;
  logic  ackSeen;
  logic  applyRules;
  logic  redirect;
  logic  countStall;
  ctrl_t ctrl;

  hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs1_i (bus.id_uses_rs1),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .hazard_o      (hazard)
  );

  // A dropped request while waiting means the access is gone, so treat it as done.
  assign ackSeen = bus.dmem_ack | ~bus.dmem_req;

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    busErr_d   = busErr_q;
    ctrl       = ctrl_run();
    applyRules = 1'b0;
    redirect   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ack) begin
          ctrl      = ctrl_freeze();
          waitCnt_d = WAIT_W'(1);
          if (DMEM_TIMEOUT <= 1) begin
            state_d  = HALT;
            busErr_d = 1'b1;
          end else begin
            state_d = DMEM_WAIT;
          end
        end else begin
          applyRules = 1'b1;
        end
      end
      DMEM_WAIT: begin
        if (ackSeen) begin
          state_d    = RUN;
          waitCnt_d  = '0;
          applyRules = 1'b1;
        end else begin
          ctrl      = ctrl_freeze();
          waitCnt_d = waitCnt_q + WAIT_W'(1);
          // waitCnt_d counts this cycle too, so the limit is reached on the last allowed wait.
          if (waitCnt_d == WAIT_LIMIT) begin
            state_d  = HALT;
            busErr_d = 1'b1;
          end
        end
      end
      HALT: begin
        ctrl = '0;
      end
      default: begin
        ctrl    = '0;
        state_d = RUN;
      end
    endcase

    if (applyRules) begin
      if (bus.ex_branch_taken) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        redirect        = 1'b1;
      end else if (hazard) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
      end else if (!bus.imem_ready) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_flush = 1'b1;
      end
    end

    if (rest) begin
      ctrl     = ctrl_reset();
      redirect = 1'b0;
    end
  end

  assign countStall = !rest && (state_q != HALT) && !ctrl.pc_en;

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      busErr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      busErr_q  <= busErr_d;
      if (countStall) stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (redirect)   flushCnt_q <= flushCnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.bus_err     = busErr_q;
  assign bus.stall_cnt   = stallCnt_q;
  assign bus.flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic, each cycle compared
// against a rule-level model of the controller (short timeout and 4-bit counters).
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;

  localparam int MODE_RUNNING = 0;
  localparam int MODE_WAITING = 1;
  localparam int MODE_HALTED  = 2;

  // Pattern order: {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  localparam logic [8:0] PAT_NORMAL = 9'b11111_0000;
  localparam logic [8:0] PAT_FREEZE = 9'b00001_0001;
  localparam logic [8:0] PAT_RESET  = 9'b00000_1111;
  localparam logic [8:0] PAT_HALT   = 9'b00000_0000;
  localparam logic [8:0] PAT_BRANCH = 9'b11111_1100;
  localparam logic [8:0] PAT_LOAD   = 9'b00111_0100;
  localparam logic [8:0] PAT_IMEM   = 9'b01111_1000;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       memRead;
    logic       branch;
    logic       imemReady;
    logic       req;
    logic       ack;
  } stim_t;

  logic clk;
  logic rest;

  pipe_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW)) bus ();

  pipe_ctrl #(.REG_ADDR_W(5), .DMEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  stim_t      curStim;
  int         mode        = MODE_RUNNING;
  int         waitCycles  = 0;
  int         stallCount  = 0;
  int         flushCount  = 0;
  bit         busErr      = 1'b0;
  logic [8:0] expCtl;
  bit         stallEvent, flushEvent;
  int         nextMode, nextWait;
  bit         nextBusErr;

  function automatic stim_t idleStim();
    stim_t s;
    s           = '0;
    s.imemReady = 1'b1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    curStim             = s;
    rest                = s.rst;
    bus.id_rs1          = s.rs1;
    bus.id_rs2          = s.rs2;
    bus.ex_rd           = s.rd;
    bus.id_uses_rs1     = s.u1;
    bus.id_uses_rs2     = s.u2;
    bus.ex_mem_read     = s.memRead;
    bus.ex_branch_taken = s.branch;
    bus.imem_ready      = s.imemReady;
    bus.dmem_req        = s.req;
    bus.dmem_ack        = s.ack;
  endtask

  // Expected behaviour of the current cycle, straight from the controller's rules.
  task automatic evalModel();
    stim_t s;
    bit    loadUse, done, rules;
    s          = curStim;
    loadUse    = s.memRead && (s.rd != 0) &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    done       = s.ack || !s.req;
    nextMode   = mode;
    nextWait   = waitCycles;
    nextBusErr = busErr;
    stallEvent = 1'b0;
    flushEvent = 1'b0;
    expCtl     = PAT_NORMAL;
    if (s.rst) begin
      expCtl = PAT_RESET;
    end else if (mode == MODE_HALTED) begin
      expCtl = PAT_HALT;
    end else begin
      rules = 1'b1;
      if (mode == MODE_RUNNING && s.req && !s.ack) begin
        rules    = 1'b0;
        nextWait = 1;
      end else if (mode == MODE_WAITING && !done) begin
        rules    = 1'b0;
        nextWait = waitCycles + 1;
      end
      if (!rules) begin
        expCtl = PAT_FREEZE;
        if (nextWait >= TIMEOUT) begin
          nextMode   = MODE_HALTED;
          nextBusErr = 1'b1;
        end else begin
          nextMode = MODE_WAITING;
        end
      end else begin
        nextMode = MODE_RUNNING;
        nextWait = 0;
        if (s.branch) begin
          expCtl     = PAT_BRANCH;
          flushEvent = 1'b1;
        end else if (loadUse) begin
          expCtl = PAT_LOAD;
        end else if (!s.imemReady) begin
          expCtl = PAT_IMEM;
        end
      end
      stallEvent = !expCtl[8];
    end
  endtask

  task automatic commitModel();
    if (curStim.rst) begin
      mode       = MODE_RUNNING;
      waitCycles = 0;
      stallCount = 0;
      flushCount = 0;
      busErr     = 1'b0;
    end else begin
      mode       = nextMode;
      waitCycles = nextWait;
      busErr     = nextBusErr;
      if (stallEvent) stallCount = (stallCount + 1) % (1 << CW);
      if (flushEvent) flushCount = (flushCount + 1) % (1 << CW);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] obsCtl;
    obsCtl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
              bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
    testCount++;
    assert (obsCtl === expCtl) else begin
      failCount++;
      $error("[TB] FAIL %s ctl observed=%b expected=%b", tag, obsCtl, expCtl);
    end
    testCount++;
    assert (bus.bus_err === busErr) else begin
      failCount++;
      $error("[TB] FAIL %s bus_err observed=%b expected=%b", tag, bus.bus_err, busErr);
    end
    testCount++;
    assert (bus.stall_cnt === CW'(stallCount)) else begin
      failCount++;
      $error("[TB] FAIL %s stall_cnt observed=%0d expected=%0d", tag, bus.stall_cnt, stallCount);
    end
    testCount++;
    assert (bus.flush_cnt === CW'(flushCount)) else begin
      failCount++;
      $error("[TB] FAIL %s flush_cnt observed=%0d expected=%0d", tag, bus.flush_cnt, flushCount);
    end
  endtask

  task automatic runCycle(input string tag, input stim_t s);
    applyStimulus(s);
    #2;
    evalModel();
    checkOutput(tag);
    @(posedge clk);
    commitModel();
    #1;
  endtask

  task automatic resetPulse();
    stim_t s;
    s     = idleStim();
    s.rst = 1'b1;
    runCycle("reset", s);
  endtask

  initial begin
    stim_t s;
    applyStimulus(idleStim());
    @(posedge clk);
    #1;

    resetPulse();
    resetPulse();
    runCycle("idle", idleStim());
    checkValue("reset_stall_cnt", int'(bus.stall_cnt), 0);
    checkValue("reset_flush_cnt", int'(bus.flush_cnt), 0);

    // Load-use on rs1 = x5, then the same pattern against x0.
    s = idleStim(); s.memRead = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    runCycle("loaduse", s);
    checkValue("loaduse_stall_cnt", int'(bus.stall_cnt), 1);
    s.rd = 0; s.rs1 = 0;
    runCycle("loaduse_x0", s);
    checkValue("loaduse_x0_stall_cnt", int'(bus.stall_cnt), 1);

    resetPulse();
    s = idleStim(); s.memRead = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; s.branch = 1;
    runCycle("branch_over_loaduse", s);
    checkValue("branch_flush_cnt", int'(bus.flush_cnt), 1);
    checkValue("branch_stall_cnt", int'(bus.stall_cnt), 0);

    // Data-memory wait with a taken branch parked in EX, ack on the third cycle.
    resetPulse();
    s = idleStim(); s.req = 1; s.branch = 1;
    runCycle("dmem_wait1", s);
    runCycle("dmem_wait2", s);
    s.ack = 1;
    runCycle("dmem_ack", s);
    runCycle("dmem_after", idleStim());
    checkValue("dmem_stall_cnt", int'(bus.stall_cnt), 2);
    checkValue("dmem_flush_cnt", int'(bus.flush_cnt), 1);

    resetPulse();
    s = idleStim(); s.req = 1;
    for (int i = 0; i < TIMEOUT; i++) runCycle("timeout_wait", s);
    s.ack = 1; s.branch = 1;
    runCycle("halted", s);
    checkValue("timeout_bus_err", int'(bus.bus_err), 1);
    checkValue("timeout_pc_en", int'(bus.pc_en), 0);
    resetPulse();
    runCycle("after_halt", idleStim());
    checkValue("recover_bus_err", int'(bus.bus_err), 0);

    resetPulse();
    s = idleStim(); s.imemReady = 0;
    runCycle("imem1", s);
    runCycle("imem2", s);
    checkValue("imem_stall_cnt", int'(bus.stall_cnt), 2);

    resetPulse();
    for (int i = 0; i < 17; i++) runCycle("wrap", s);
    checkValue("wrap_stall_cnt", int'(bus.stall_cnt), 1);

    for (int i = 0; i < 500; i++) begin
      s           = idleStim();
      s.rst       = ($urandom_range(0, 49) == 0) ||
                    (mode == MODE_HALTED && $urandom_range(0, 3) == 0);
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.rd        = 5'($urandom_range(0, 3));
      s.u1        = 1'($urandom_range(0, 1));
      s.u2        = 1'($urandom_range(0, 1));
      s.memRead   = 1'($urandom_range(0, 1));
      s.branch    = ($urandom_range(0, 4) == 0);
      s.imemReady = ($urandom_range(0, 3) != 0);
      s.req       = ($urandom_range(0, 2) == 0);
      s.ack       = 1'($urandom_range(0, 1));
      runCycle("random", s);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
